// File: rtl/apb_perceptron_engine.sv
// APB-slave perceptron: weight/image RAMs, sequential MAC over a programmable length, bias, decision.
// Optional registered interrupt output is enabled by defining APB_PERCEPTRON_IRQ_EN.
module apb_perceptron_engine #(
  parameter int unsigned Amba_Word       = 24,
  parameter int unsigned Amba_Addr_Depth = 12,
  parameter int unsigned WeightPrecision = 5,
  parameter int unsigned PixWidth        = 8,
  parameter int unsigned NWords          = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [Amba_Addr_Depth-1:0] PADDR,
  input  logic [Amba_Word-1:0]       PWDATA,
  output logic [Amba_Word-1:0]       PRDATA,
  output logic                       CatRecOut
`ifdef APB_PERCEPTRON_IRQ_EN
  ,
  output logic                       irq
`endif
);

  localparam int PixPerWord = int'(Amba_Word / PixWidth);
  localparam int PtrW       = (NWords > 1) ? $clog2(NWords) : 1;
  localparam int AccW       = int'(PixWidth + WeightPrecision) +
                              $clog2(PixPerWord * int'(NWords)) + 1;
  localparam int HiW        = int'(Amba_Addr_Depth) - 8;
  localparam logic [8:0] NWordsLen = 9'(NWords);
`ifdef APB_PERCEPTRON_IRQ_EN
  localparam logic IrqEn = 1'b1;
`else
  localparam logic IrqEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StFinal, StDone} state_t;

  logic [Amba_Word-1:0] r_wram [NWords];
  logic [Amba_Word-1:0] r_iram [NWords];

  state_t                      r_state;
  logic [PtrW-1:0]             r_ptr;
  logic signed [AccW-1:0]      r_acc;
  logic signed [WeightPrecision-1:0] r_bias;
  logic [8:0]                  r_len;
  logic                        r_ie;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_err;
  logic                        r_cat;
  logic [Amba_Word-1:0]        r_prdata;

  logic [HiW-1:0]         w_hi;
  logic [7:0]             w_idx;
  logic [PtrW-1:0]        w_ram_idx;
  logic                   w_in_range, w_csr, w_wram_sel, w_iram_sel;
  logic                   w_wr, w_rd_setup;
  logic                   w_wr_ctrl, w_wr_stat, w_wr_bias, w_wr_len;
  logic                   w_cfg_wr, w_cfg_ok, w_err_set, w_clr, w_start;
  logic [8:0]             w_len_eff;
  logic                   w_last;
  logic signed [AccW-1:0] w_mac;
  logic [Amba_Word-1:0]   w_rdata;

  // Unsigned pixel lanes times signed low-order weight lanes, summed across the word.
  function automatic logic signed [AccW-1:0] mac_word(input logic [Amba_Word-1:0] pix_w,
                                                      input logic [Amba_Word-1:0] wgt_w);
    logic signed [AccW-1:0] sum;
    logic signed [AccW-1:0] p;
    logic signed [AccW-1:0] w;
    sum = '0;
    for (int i = 0; i < PixPerWord; i++) begin
      p   = AccW'(pix_w[i*PixWidth +: PixWidth]);
      w   = AccW'($signed(wgt_w[i*PixWidth +: WeightPrecision]));
      sum = sum + p * w;
    end
    return sum;
  endfunction

  assign w_hi       = PADDR[Amba_Addr_Depth-1:8];
  assign w_idx      = PADDR[7:0];
  assign w_ram_idx  = w_idx[PtrW-1:0];
  assign w_in_range = ({1'b0, w_idx} < NWordsLen);
  assign w_csr      = (w_hi == '0);
  assign w_wram_sel = (w_hi == HiW'(1)) && w_in_range;
  assign w_iram_sel = (w_hi == HiW'(2)) && w_in_range;

  assign w_wr       = PSEL & PENABLE & PWRITE;
  assign w_rd_setup = PSEL & ~PENABLE & ~PWRITE;
  assign w_wr_ctrl  = w_wr & w_csr & (w_idx == 8'h00);
  assign w_wr_stat  = w_wr & w_csr & (w_idx == 8'h01);
  assign w_wr_bias  = w_wr & w_csr & (w_idx == 8'h02);
  assign w_wr_len   = w_wr & w_csr & (w_idx == 8'h03);

  assign w_cfg_wr   = w_wr_bias | w_wr_len | (w_wr & (w_wram_sel | w_iram_sel));
  assign w_cfg_ok   = w_cfg_wr & ~r_busy;
  assign w_err_set  = w_cfg_wr & r_busy;
  assign w_clr      = w_wr_ctrl & PWDATA[1];
  assign w_start    = w_wr_ctrl & PWDATA[0] & ~PWDATA[1];

  assign w_len_eff  = (r_len > NWordsLen) ? NWordsLen : r_len;
  assign w_last     = (9'(r_ptr) == (w_len_eff - 9'd1));
  assign w_mac      = mac_word(r_iram[r_ptr], r_wram[r_ptr]);

  always_ff @(posedge clk) begin
    if (w_cfg_ok && w_wram_sel) r_wram[w_ram_idx] <= PWDATA;
    if (w_cfg_ok && w_iram_sel) r_iram[w_ram_idx] <= PWDATA;
  end

  always_comb begin
    w_rdata = '0;
    if (w_csr) begin
      case (w_idx)
        8'h00:   w_rdata[2]   = r_ie;
        8'h01:   w_rdata[2:0] = {r_err, r_done, r_busy};
        8'h02:   w_rdata      = Amba_Word'(r_bias);
        8'h03:   w_rdata      = Amba_Word'(r_len);
        8'h04:   w_rdata      = Amba_Word'(r_acc);
        default: w_rdata      = '0;
      endcase
    end else if (w_wram_sel) begin
      w_rdata = r_wram[w_ram_idx];
    end else if (w_iram_sel) begin
      w_rdata = r_iram[w_ram_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_acc    <= '0;
      r_bias   <= '0;
      r_len    <= '0;
      r_ie     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cat    <= 1'b0;
      r_prdata <= '0;
    end else begin
      if (w_err_set)                   r_err <= 1'b1;
      else if (w_wr_stat && PWDATA[2]) r_err <= 1'b0;
      if (w_wr_stat && PWDATA[1])      r_done <= 1'b0;
      if (w_cfg_ok && w_wr_bias)       r_bias <= PWDATA[WeightPrecision-1:0];
      if (w_cfg_ok && w_wr_len)        r_len <= PWDATA[8:0];
      if (w_wr_ctrl)                   r_ie <= PWDATA[2] & IrqEn;
      if (w_rd_setup)                  r_prdata <= w_rdata;

      // CLR overrides whatever the sequencer would do this cycle, including a completion.
      if (w_clr) begin
        r_state <= StIdle;
        r_ptr   <= '0;
        r_acc   <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_cat   <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (w_start) begin
              r_acc   <= '0;
              r_ptr   <= '0;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_state <= (w_len_eff == 9'd0) ? StFinal : StRun;
            end
          end
          StRun: begin
            r_acc <= r_acc + w_mac;
            if (w_last) r_state <= StFinal;
            else        r_ptr   <= r_ptr + PtrW'(1);
          end
          StFinal: begin
            r_acc   <= r_acc + AccW'(r_bias);
            r_state <= StDone;
          end
          StDone: begin
            r_cat   <= ~r_acc[AccW-1];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign PRDATA    = r_prdata;
  assign CatRecOut = r_cat;

`ifdef APB_PERCEPTRON_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_irq <= 1'b0;
    else if (w_clr || (w_wr_stat && PWDATA[1])) r_irq <= 1'b0;
    else                                    r_irq <= r_done & r_ie;
  end

  assign irq = r_irq;
`endif

endmodule
